// File: rtl/aes_inv_key_schedule_if.sv
// Round-key delivery bus of the AES-128 inverse key scheduler.
// The scheduler drives the master side; the decryption datapath is the slave.
interface aes_inv_key_schedule_if #(
    parameter int ROUND_W = 4
);
    logic               key_valid;
    logic               key_ready;
    logic [127:0]       key_out;
    logic [ROUND_W-1:0] round_out;

    modport master (output key_valid, key_out, round_out, input key_ready);
    modport slave  (input key_valid, key_out, round_out, output key_ready);
endinterface

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 inverse key scheduler: delivers round keys 10..0, one 2-cycle step per key.
// Optional AES_INV_KS_FWD_PRELOAD_EN: accept the cipher key and expand forward to round 10 first.
module aes_inv_key_schedule #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [127:0]                  key_in,
`ifdef AES_INV_KS_FWD_PRELOAD_EN
    input  logic                          key_is_cipher,
`endif
    output logic                          busy,
    output logic                          done,
    aes_inv_key_schedule_if.master        kbus
);

`ifdef AES_INV_KS_FWD_PRELOAD_EN
    typedef enum logic [2:0] {IDLE, HOLD, ROT, SUB, FWD} state_t;
    logic fwd_ph;
`else
    typedef enum logic [1:0] {IDLE, HOLD, ROT, SUB} state_t;
`endif

    state_t      state;
    logic [31:0] stp;
    logic [95:0] t;
    logic [31:0] w0_new;
    logic [31:0] sub_w;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] rcon(input logic [ROUND_W-1:0] r);
        logic [7:0] b;
        case (r)
            ROUND_W'(1):  b = 8'h01;
            ROUND_W'(2):  b = 8'h02;
            ROUND_W'(3):  b = 8'h04;
            ROUND_W'(4):  b = 8'h08;
            ROUND_W'(5):  b = 8'h10;
            ROUND_W'(6):  b = 8'h20;
            ROUND_W'(7):  b = 8'h40;
            ROUND_W'(8):  b = 8'h80;
            ROUND_W'(9):  b = 8'h1b;
            ROUND_W'(10): b = 8'h36;
            default:      b = 8'h00;
        endcase
        return {b, 24'h0};
    endfunction

    // Backward words 1..3 are pure XORs of the current key; word 0 needs SubWord of new word 3.
    // The same word-0 expression serves the forward expansion step.
    always_comb begin
        t[95:64] = kbus.key_out[95:64] ^ kbus.key_out[127:96];
        t[63:32] = kbus.key_out[63:32] ^ kbus.key_out[95:64];
        t[31:0]  = kbus.key_out[31:0]  ^ kbus.key_out[63:32];
        sub_w    = subword(stp);
        w0_new   = kbus.key_out[127:96] ^ sub_w ^ rcon(kbus.round_out);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            kbus.key_valid <= 1'b0;
            kbus.key_out   <= '0;
            kbus.round_out <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            stp            <= '0;
`ifdef AES_INV_KS_FWD_PRELOAD_EN
            fwd_ph         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (start) begin
                // Start aborts any walk, but an accepted round-0 key still reports done.
                if (state == HOLD && kbus.key_ready && kbus.round_out == '0)
                    done <= 1'b1;
                kbus.key_out   <= key_in;
                busy           <= 1'b1;
                state          <= HOLD;
                kbus.key_valid <= 1'b1;
                kbus.round_out <= ROUND_W'(NR);
`ifdef AES_INV_KS_FWD_PRELOAD_EN
                fwd_ph <= 1'b0;
                if (key_is_cipher) begin
                    state          <= FWD;
                    kbus.key_valid <= 1'b0;
                    kbus.round_out <= ROUND_W'(1);
                end
`endif
            end else begin
                case (state)
                    IDLE: ;
                    HOLD: begin
                        if (kbus.key_ready) begin
                            kbus.key_valid <= 1'b0;
                            if (kbus.round_out == '0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ROT;
                            end
                        end
                    end
                    ROT: begin
                        kbus.key_out[95:0] <= t;
                        stp                <= rotword(t[31:0]);
                        state              <= SUB;
                    end
                    SUB: begin
                        kbus.key_out[127:96] <= w0_new;
                        kbus.round_out       <= kbus.round_out - ROUND_W'(1);
                        kbus.key_valid       <= 1'b1;
                        state                <= HOLD;
                    end
`ifdef AES_INV_KS_FWD_PRELOAD_EN
                    FWD: begin
                        if (!fwd_ph) begin
                            stp    <= rotword(kbus.key_out[31:0]);
                            fwd_ph <= 1'b1;
                        end else begin
                            kbus.key_out <= {w0_new,
                                             w0_new ^ kbus.key_out[95:64],
                                             w0_new ^ kbus.key_out[95:64] ^ kbus.key_out[63:32],
                                             w0_new ^ kbus.key_out[95:64] ^ kbus.key_out[63:32] ^ kbus.key_out[31:0]};
                            fwd_ph <= 1'b0;
                            if (kbus.round_out == ROUND_W'(NR)) begin
                                state          <= HOLD;
                                kbus.key_valid <= 1'b1;
                            end else begin
                                kbus.round_out <= kbus.round_out + ROUND_W'(1);
                            end
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule: scoreboard of expected round keys (FIPS-197 A.1).
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
`ifdef AES_INV_KS_FWD_PRELOAD_EN
    logic         key_is_cipher;
`endif

    aes_inv_key_schedule_if #(.ROUND_W(4)) kbus ();

    aes_inv_key_schedule #(.NR(10), .ROUND_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .key_in        (key_in),
`ifdef AES_INV_KS_FWD_PRELOAD_EN
        .key_is_cipher (key_is_cipher),
`endif
        .busy          (busy),
        .done          (done),
        .kbus          (kbus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   r;
        logic [127:0] k;
    } exp_t;

    exp_t         sbq[$];
    logic [127:0] rk [0:10];
    int unsigned  total = 0;
    int unsigned  bad = 0;
    int unsigned  done_cnt = 0;

    localparam logic [127:0] KX = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KY = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: monitor at negedge (count done, score accepted keys), return at posedge+1.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (kbus.key_valid === 1'b1 && kbus.key_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_key", 128'(kbus.round_out), 128'hf);
            end else begin
                e = sbq.pop_front();
                check("sb_round", 128'(kbus.round_out), 128'(e.r));
                check("sb_key", kbus.key_out, e.k);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_walk();
        for (int r = 10; r >= 0; r--) sbq.push_back('{r: 4'(r), k: rk[r]});
    endtask

    task automatic do_start(input logic [127:0] k, input logic cipher);
        start  = 1'b1;
        key_in = k;
`ifdef AES_INV_KS_FWD_PRELOAD_EN
        key_is_cipher = cipher;
`else
        if (cipher) $display("note: cipher preload not built");
`endif
        tick();
        start = 1'b0;
`ifdef AES_INV_KS_FWD_PRELOAD_EN
        key_is_cipher = 1'b0;
`endif
    endtask

    task automatic wait_round(input logic [3:0] r, input int budget);
        int n = 0;
        while (!(kbus.key_valid === 1'b1 && kbus.round_out === r) && n < budget) begin
            tick();
            n++;
        end
        check("wait_round", 128'({kbus.key_valid, kbus.round_out}), 128'({1'b1, r}));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset = 1'b1;
        start = 1'b0;
        key_in = '0;
        kbus.key_ready = 1'b0;
`ifdef AES_INV_KS_FWD_PRELOAD_EN
        key_is_cipher = 1'b0;
`endif
        run(2);
        reset = 1'b0;
        check("rst_valid", 128'(kbus.key_valid), 128'(0));
        check("rst_key", kbus.key_out, '0);
        check("rst_round", 128'(kbus.round_out), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));

        // Full walk with the consumer always ready.
        kbus.key_ready = 1'b1;
        done_cnt = 0;
        push_walk();
        do_start(rk[10], 1'b0);
        check("t1_valid", 128'(kbus.key_valid), 128'(1));
        check("t1_round", 128'(kbus.round_out), 128'(10));
        check("t1_key", kbus.key_out, rk[10]);
        run(35);
        check("t1_done", 128'(done_cnt), 128'(1));
        check("t1_sb_left", 128'(sbq.size()), 128'(0));
        check("t1_busy", 128'(busy), 128'(0));
        check("t1_idle_valid", 128'(kbus.key_valid), 128'(0));

        // Backpressure at round 7, then handshake-to-next-key latency.
        done_cnt = 0;
        push_walk();
        do_start(rk[10], 1'b0);
        wait_round(4'd7, 40);
        kbus.key_ready = 1'b0;
        run(5);
        check("t2_hold_valid", 128'(kbus.key_valid), 128'(1));
        check("t2_hold_round", 128'(kbus.round_out), 128'(7));
        check("t2_hold_key", kbus.key_out, rk[7]);
        kbus.key_ready = 1'b1;
        tick();
        tick();
        check("t2_gap_valid", 128'(kbus.key_valid), 128'(0));
        tick();
        check("t2_next_valid", 128'(kbus.key_valid), 128'(1));
        check("t2_next_round", 128'(kbus.round_out), 128'(6));
        run(30);
        check("t2_done", 128'(done_cnt), 128'(1));
        check("t2_sb_left", 128'(sbq.size()), 128'(0));

        // Restart while in ROT after round 4 accepted.
        done_cnt = 0;
        push_walk();
        do_start(rk[10], 1'b0);
        wait_round(4'd4, 40);
        tick();
        check("t3_rot_busy", 128'(busy), 128'(1));
        check("t3_rot_valid", 128'(kbus.key_valid), 128'(0));
        sbq.delete();
        sbq.push_back('{r: 4'd10, k: KX});
        do_start(KX, 1'b0);
        check("t3_round", 128'(kbus.round_out), 128'(10));
        check("t3_key", kbus.key_out, KX);
        check("t3_valid", 128'(kbus.key_valid), 128'(1));
        tick();
        sbq.delete();
        push_walk();
        do_start(rk[10], 1'b0);
        run(35);
        check("t3_done", 128'(done_cnt), 128'(1));
        check("t3_sb_left", 128'(sbq.size()), 128'(0));

        // Reset during SUB discards the step, no done.
        done_cnt = 0;
        push_walk();
        do_start(rk[10], 1'b0);
        tick();
        tick();
        check("t4_sub_busy", 128'(busy), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_valid", 128'(kbus.key_valid), 128'(0));
        check("t4_busy", 128'(busy), 128'(0));
        check("t4_key", kbus.key_out, '0);
        check("t4_round", 128'(kbus.round_out), 128'(0));
        sbq.delete();
        run(5);
        check("t4_no_done", 128'(done_cnt), 128'(0));
        check("t4_still_idle", 128'(kbus.key_valid), 128'(0));

        // Start in the same cycle as round-0 acceptance.
        done_cnt = 0;
        push_walk();
        do_start(rk[10], 1'b0);
        wait_round(4'd0, 40);
        sbq.push_back('{r: 4'd10, k: KY});
        do_start(KY, 1'b0);
        check("t5_done", 128'(done), 128'(1));
        check("t5_round", 128'(kbus.round_out), 128'(10));
        check("t5_key", kbus.key_out, KY);
        check("t5_valid", 128'(kbus.key_valid), 128'(1));
        tick();
        check("t5_done_pulse", 128'(done), 128'(0));
        check("t5_done_cnt", 128'(done_cnt), 128'(1));
        check("t5_sb_left", 128'(sbq.size()), 128'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sbq.delete();

`ifdef AES_INV_KS_FWD_PRELOAD_EN
        // Cipher-key preload: forward expansion then full backward walk.
        begin
            int n;
            done_cnt = 0;
            push_walk();
            do_start(rk[0], 1'b1);
            check("t6_fwd_valid", 128'(kbus.key_valid), 128'(0));
            check("t6_fwd_busy", 128'(busy), 128'(1));
            n = 1;
            while (kbus.key_valid !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("t6_latency", 128'(n), 128'(21));
            check("t6_key", kbus.key_out, rk[10]);
            check("t6_round", 128'(kbus.round_out), 128'(10));
            run(35);
            check("t6_done", 128'(done_cnt), 128'(1));
            check("t6_sb_left", 128'(sbq.size()), 128'(0));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
